// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
package apb_arb_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;

    localparam logic [APB_AW-1:0] DEFAULT_BASE_ADDR = 32'h7000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } apb_arb_state_e;

    // Unsigned subtract: addresses below the base wrap to huge values and fall outside.
    function automatic logic in_window(input logic [APB_AW-1:0] addr,
                                       input logic [APB_AW-1:0] base,
                                       input int unsigned       size);
        return (addr - base) < size;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last+1, pointer moves only on advance.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned IdxW = $clog2(N);

    logic [IdxW-1:0] last_q, last_d;
    logic [IdxW-1:0] idx;
    logic [IdxW-1:0] win;

    always_comb begin
        grant = '0;
        win   = last_q;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IdxW'((32'(last_q) + k) % N);
            if (req[idx] && (grant == '0)) begin
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance && (grant != '0)) begin
            last_d = win;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= IdxW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant, SETUP/ACCESS sequencing,
// address window filter and ACCESS timeout.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned       NUM_REQ      = 2,
    parameter logic [APB_AW-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int unsigned       WINDOW_BYTES = 16,
    parameter int unsigned       TIMEOUT_CYC  = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*APB_AW-1:0] req_addr,
    input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [APB_DW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [APB_AW-1:0]         paddr,
    output logic [APB_DW-1:0]         pwdata,
    input  logic [APB_DW-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    apb_arb_state_e    state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [APB_AW-1:0] paddr_q, paddr_d;
    logic [APB_DW-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [APB_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic               advance;
    logic [IdxW-1:0]    win;
    logic               sel_write;
    logic [APB_AW-1:0]  sel_addr;
    logic [APB_DW-1:0]  sel_wdata;

    assign advance = (state_q == StIdle) && (req_valid != '0);

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i   (pclk),
        .rst_ni  (presetn),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        win       = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win       = IdxW'(i);
                sel_write = req_write[i];
                sel_addr  = req_addr[i*APB_AW +: APB_AW];
                sel_wdata = req_wdata[i*APB_DW +: APB_DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        rsp_valid = '0;
        psel      = 1'b0;
        penable   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (advance) begin
                    req_ready = grant;
                    idx_d     = win;
                    if (in_window(sel_addr, BASE_ADDR, WINDOW_BYTES)) begin
                        paddr_d  = sel_addr;
                        pwdata_d = sel_wdata;
                        pwrite_d = sel_write;
                        state_d  = StSetup;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StSetup: begin
                psel    = 1'b1;
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                psel    = 1'b1;
                penable = 1'b1;
                // pready is checked first so a same-cycle timeout still completes normally.
                if (pready) begin
                    rdata_d = pwrite_q ? '0 : prdata;
                    err_d   = pslverr;
                    cnt_d   = '0;
                    state_d = StResp;
                end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                rsp_valid[idx_q] = 1'b1;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small byte-offset APB slave memory.
module tb_apb_master_arbiter;

    logic        pclk;
    logic        presetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic        slv_ready;
    logic        slv_err;
    logic [31:0] mem [16] = '{default: 32'h0};

    int vectors     = 0;
    int miscompares = 0;

    apb_master_arbiter u_dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    assign pready  = slv_ready;
    assign pslverr = slv_err;
    assign prdata  = mem[paddr[3:0]];

    always @(posedge pclk) begin
        if (psel && penable && pready && pwrite) begin
            mem[paddr[3:0]] <= pwdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer from requester r with the slave answering in the first ACCESS cycle.
    task automatic xfer(input int r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input logic in_win);
        int n;
        @(negedge pclk);
        req_valid[r]            = 1'b1;
        req_write[r]            = w;
        req_addr[r*32 +: 32]    = a;
        req_wdata[r*32 +: 32]   = d;
        #1;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 20) begin
            @(negedge pclk);
            #1;
            n++;
        end
        chk("accept", 32'(req_ready), 32'(1 << r));
        chk("idle_psel", 32'(psel), 32'd0);
        @(negedge pclk);
        req_valid[r] = 1'b0;
        #1;
        if (in_win) begin
            chk("setup_ctl", 32'({psel, penable}), 32'h2);
            chk("setup_paddr", paddr, a);
            chk("setup_pwrite", 32'(pwrite), 32'(w));
            if (w) chk("setup_pwdata", pwdata, d);
            @(negedge pclk);
            #1;
            chk("access_ctl", 32'({psel, penable}), 32'h3);
            chk("access_paddr", paddr, a);
            @(negedge pclk);
            #1;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << r));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_psel", 32'({psel, penable}), 32'h0);
    endtask

    logic [7:0] ascii [4] = '{8'h47, 8'h4C, 8'h55, 8'h53};

    initial begin
        int n;
        int act;
        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        slv_ready = 1'b1;
        slv_err   = 1'b0;

        #12;
        chk("rst_psel", 32'({psel, penable, pwrite}), 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp", 32'(rsp_valid), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        @(negedge pclk);
        presetn = 1'b1;

        // Write then read back from the other requester.
        xfer(0, 1'b1, 32'h7000_0004, 32'd9, 32'h0, 1'b0, 1'b1);
        xfer(1, 1'b0, 32'h7000_0004, 32'h0, 32'd9, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            xfer(0, 1'b1, 32'h7000_0008 + 32'(k), 32'(ascii[k]), 32'h0, 1'b0, 1'b1);
            xfer(1, 1'b0, 32'h7000_0008 + 32'(k), 32'h0, 32'(ascii[k]), 1'b0, 1'b1);
        end

        // Out-of-window: below base and one past the top.
        xfer(0, 1'b0, 32'h6FFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b0);
        xfer(1, 1'b1, 32'h7000_0010, 32'h5, 32'h0, 1'b1, 1'b0);
        chk("oow_paddr_held", paddr, 32'h7000_000B);

        // Slave error is propagated along with the read data.
        slv_err = 1'b1;
        xfer(1, 1'b0, 32'h7000_0004, 32'h0, 32'd9, 1'b1, 1'b1);
        slv_err = 1'b0;

        // Timeout: 16 ACCESS cycles, response 18 cycles after acceptance.
        slv_ready = 1'b0;
        @(negedge pclk);
        req_valid[0]     = 1'b1;
        req_write[0]     = 1'b0;
        req_addr[31:0]   = 32'h7000_0008;
        #1;
        chk("to_accept", 32'(req_ready), 32'h1);
        n   = 0;
        act = 0;
        do begin
            @(negedge pclk);
            req_valid[0] = 1'b0;
            #1;
            n++;
            if (psel && penable) act++;
        end while (rsp_valid == '0 && n < 40);
        chk("to_latency", 32'(n), 32'd18);
        chk("to_access_cycles", 32'(act), 32'd16);
        chk("to_rsp", 32'(rsp_valid), 32'h1);
        chk("to_err", 32'(rsp_err), 32'h1);
        chk("to_rdata", rsp_rdata, 32'h0);
        chk("to_bus_idle", 32'({psel, penable}), 32'h0);
        slv_ready = 1'b1;
        xfer(1, 1'b0, 32'h7000_0008, 32'h0, 32'h47, 1'b0, 1'b1);

        // Reset while in ACCESS.
        slv_ready = 1'b0;
        xfer_start_read: begin
            @(negedge pclk);
            req_valid[1]    = 1'b1;
            req_write[1]    = 1'b0;
            req_addr[63:32] = 32'h7000_0009;
            #1;
            chk("mr_accept", 32'(req_ready), 32'h2);
            @(negedge pclk);
            req_valid[1] = 1'b0;
            @(negedge pclk);
            #1;
            chk("mr_access", 32'({psel, penable}), 32'h3);
            #2;
            presetn = 1'b0;
            #1;
            chk("mr_ctl", 32'({psel, penable, pwrite}), 32'h0);
            chk("mr_paddr", paddr, 32'h0);
            chk("mr_pwdata", pwdata, 32'h0);
            chk("mr_rsp", 32'(rsp_valid), 32'h0);
            chk("mr_rdata", rsp_rdata, 32'h0);
            chk("mr_err", 32'(rsp_err), 32'h0);
        end
        slv_ready = 1'b1;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        #1;
        chk("mr_no_rsp", 32'(rsp_valid), 32'h0);

        // Contention straight after reset: 0,1,0,1,... starting with requester 0.
        req_write       = 2'b00;
        req_addr[31:0]  = 32'h7000_0004;
        req_addr[63:32] = 32'h7000_0004;
        @(posedge pclk);
        #1;
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            do begin
                @(negedge pclk);
                #1;
                n++;
            end while (req_ready == '0 && n < 10);
            chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge pclk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

APB master that shares a single APB bus between `NUM_REQ` internal requesters. It arbitrates round-robin and sequences the SETUP/ACCESS phases to the downstream `apb_slave`. It also blocks out-of-window addresses and aborts transfers that hang. It sits between on-chip request sources (CPU bridge, DMA) and the peripheral register file at `32'h7000_0000`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `BASE_ADDR`, `32'h7000_0000`: decoded window base.
- `WINDOW_BYTES`, 16: decoded window size; power of two.
- `TIMEOUT_CYC`, 16: maximum ACCESS cycles waiting for `pready`; range 2..255.

Ports (clock and reset first):
- Clocking: one clock; reset is asynchronous and active-low.
  - `pclk`, in, 1: clock.
  - `presetn`, in, 1: asynchronous active-low reset.
- Request channel, all requesters flattened:
  - `req_valid`, in, NUM_REQ: request pending per requester.
  - `req_ready`, out, NUM_REQ: one-hot, one-cycle accept pulse.
  - `req_write`, in, NUM_REQ: 1 = write.
  - `req_addr`, in, NUM_REQ×32: byte address.
  - `req_wdata`, in, NUM_REQ×32: write data.
- Response channel:
  - `rsp_valid`, out, NUM_REQ: one-hot, one-cycle completion pulse.
  - `rsp_rdata`, out, 32: read data, valid with `rsp_valid`.
  - `rsp_err`, out, 1: error flag, valid with `rsp_valid`.
- APB master side:
  - `psel`, `penable`, `pwrite`, out, 1 each: APB control.
  - `paddr`, `pwdata`, out, 32 each: APB address and data.
  - `prdata`, in, 32: slave read data.
  - `pready`, `pslverr`, in, 1 each: slave response.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any `req_valid` is high, grant the round-robin winner i.
  - Pulse `req_ready[i]` in that cycle.
  - Latch write/addr/wdata and the requester index.
  - If the address is in the window, go to SETUP. Otherwise go to RESP with err=1 and rdata=0. No APB activity occurs for an out-of-window address.
- SETUP: `psel`=1, `penable`=0, with paddr/pwrite/pwdata driven from the latch. Go to ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1. The timeout counter increments each cycle.
  - When `pready`=1: capture `prdata` (reads only; writes return 0) and `pslverr`, then go to RESP.
  - When the counter reaches `TIMEOUT_CYC` with `pready` still 0: err=1, rdata=0, go to RESP.
- RESP: `psel`=`penable`=0. Pulse `rsp_valid[idx]` with the captured rdata/err. Go to IDLE.
- Window check: in-window when `(addr - BASE_ADDR) < WINDOW_BYTES`, using a 32-bit unsigned subtract so wrap below the base counts as out of window.
- Round-robin:
  - A `last` pointer updates only on grant.
  - Search order is `last+1` .. `last+NUM_REQ`, modulo `NUM_REQ`.
  - Reset value of `last` is `NUM_REQ-1`, so requester 0 wins first.
- Requester rule: a requester must hold its `req_valid` and payload stable until `req_ready`. It may deassert only after acceptance.
- paddr, pwrite and pwdata hold their values from SETUP through ACCESS. Outside a transfer they hold their last value; only the control signals matter when idle.

## Timing
- Reset values (async on `presetn`=0): state=IDLE; `psel`=`penable`=`pwrite`=0; `paddr`=`pwdata`=0; `req_ready`=`rsp_valid`=0; `rsp_rdata`=0; `rsp_err`=0; timeout counter=0; `last`=NUM_REQ-1.
- Latency, with acceptance in cycle T:
  - T+1: `psel` rises.
  - T+2: `penable` rises.
  - If `pready` is sampled 1 at the end of T+2, `rsp_valid` is high in T+3 and the next acceptance can happen in T+4.
  - Minimum occupancy is 4 cycles per transfer.
- Out-of-window request: `rsp_valid` in T+1; next acceptance in T+2.
- Timeout: `rsp_valid` arrives `TIMEOUT_CYC` cycles after `penable` first rises. `psel` and `penable` drop together.
- Simultaneous events:
  - If `pready` and the timeout fire in the same cycle, `pready` wins (normal completion).
  - New requests arriving during a transfer wait; there is no preemption.
- Reset mid-transfer: the bus returns to idle immediately, no `rsp_valid` is issued, and the lost request is not replayed.

## Structure
- `apb_arb_pkg` holds:
  - state enum `apb_arb_state_e` (IDLE, SETUP, ACCESS, RESP);
  - `APB_AW` = `APB_DW` = 32;
  - the default `BASE_ADDR` constant.
- Sub-module `rr_arbiter #(N)`: inputs `req[N]`, `advance`; output `grant[N]` (one-hot); owns the `last` pointer.

## Test plan
- Write: req0 writes 9 to `0x7000_0004`, slave `pready`=1 in the first ACCESS cycle. Required: `psel` at T+1, `penable` at T+2, `rsp_valid[0]` at T+3, err=0.
- Read: req1 reads `0x7000_0004`. Required: `rsp_valid[1]`, rdata=9, err=0. Repeat for ASCII bytes `0x47`/`0x4C`/`0x55`/`0x53` at offsets 8..B; each read returns the same byte.
- Contention: both requesters hold `req_valid` continuously. Required: grants alternate 0,1,0,1 across 8 transfers, with the first grant to req0 after reset.
- Out of window: access to `0x6FFF_FFFC` and to `0x7000_0010`. Required: err=1 and rdata=0 at T+1, with `psel` never asserted.
- Timeout: slave holds `pready`=0. Required: err=1 and rdata=0 after 16 ACCESS cycles, then `psel`/`penable` low; a following transfer completes normally.
- Reset during ACCESS: pull `presetn` low. Required: all outputs at reset values immediately, no `rsp_valid`, and req0 wins the first grant after release.
